// File: rtl/joy2quad_multi.sv
// joy2quad_multi: multi-channel joystick/stick to quadrature (Gray code)
// encoder converter with hold-time acceleration and an analog
// proportional-speed mode. Each channel emits {A,B} phases plus a one-cycle
// step strobe on every phase change.
module joy2quad_multi #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 3,
  parameter int ACCEL_HOLD  = 16,
  parameter int DEADZONE    = 12
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [DIV_W-1:0]        clkdiv,
  input  logic                    accel_en,
  input  logic                    mode,
  input  logic [CHANNELS-1:0]     left,
  input  logic [CHANNELS-1:0]     right,
  input  logic [8*CHANNELS-1:0]   analog,
  output logic [2*CHANNELS-1:0]   steer,
  output logic [CHANNELS-1:0]     step
);

  localparam int HOLD_W = (ACCEL_HOLD < 1) ? 1 : $clog2(ACCEL_HOLD + 1);
  localparam int LVL_W  = (ACCEL_STEPS < 1) ? 1 : $clog2(ACCEL_STEPS + 1);

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  // |v| with the one unrepresentable magnitude (-128) pinned to 127
  function automatic logic [7:0] stick_mag(input logic signed [7:0] v);
    logic [7:0] m;
    if (v == 8'sh80)   m = 8'd127;
    else if (v < 0)    m = $unsigned(-v);
    else               m = $unsigned(v);
    return m;
  endfunction

  function automatic dir_e analog_dir(input logic signed [7:0] v);
    dir_e d;
    d = DIR_NONE;
    if (int'(v) > DEADZONE)       d = DIR_CW;
    else if (int'(v) < -DEADZONE) d = DIR_CCW;
    return d;
  endfunction

  // Speed level grows by one every 32 counts of stick deflection
  function automatic logic [LVL_W-1:0] analog_level(input logic signed [7:0] v);
    int lv;
    lv = int'(stick_mag(v) >> 5);
    if (lv > ACCEL_STEPS) lv = ACCEL_STEPS;
    return LVL_W'(lv);
  endfunction

  function automatic dir_e digital_dir(input logic l, input logic r);
    dir_e d;
    d = DIR_NONE;
    if (r && !l)      d = DIR_CW;
    else if (l && !r) d = DIR_CCW;
    return d;
  endfunction

  // Step period in clocks; a zero divider or an over-shifted one still
  // yields one step per clock rather than stalling
  function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] base,
                                                  input logic [LVL_W-1:0] lvl);
    logic [DIV_W-1:0] b;
    logic [DIV_W-1:0] p;
    b = (base == '0) ? DIV_W'(1) : base;
    p = b >> lvl;
    if (p == '0) p = DIV_W'(1);
    return p;
  endfunction

  // Gray sequence CW: 00 -> 01 -> 11 -> 10 -> 00, CCW walks it backwards
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic cw);
    logic [1:0] n;
    case (ph)
      2'b00:   n = cw ? 2'b01 : 2'b10;
      2'b01:   n = cw ? 2'b11 : 2'b00;
      2'b11:   n = cw ? 2'b10 : 2'b01;
      default: n = cw ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  logic [1:0]        steer_q [CHANNELS];
  logic              step_q  [CHANNELS];
  logic [DIV_W-1:0]  presc_q [CHANNELS];
  logic [LVL_W-1:0]  level_q [CHANNELS];
  logic [HOLD_W-1:0] hold_q  [CHANNELS];
  dir_e              lastdir_q [CHANNELS];
  logic              mode_q;

  dir_e              req_dir [CHANNELS];
  logic [LVL_W-1:0]  eff_lvl [CHANNELS];
  logic [DIV_W-1:0]  eff_per [CHANNELS];

  // Per-channel requested direction, active speed level and step period
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      req_dir[n] = DIR_NONE;
      eff_lvl[n] = '0;
      if (mode) begin
        req_dir[n] = analog_dir(analog[8*n +: 8]);
        eff_lvl[n] = analog_level(analog[8*n +: 8]);
      end else begin
        req_dir[n] = digital_dir(left[n], right[n]);
        eff_lvl[n] = accel_en ? level_q[n] : '0;
      end
      eff_per[n] = eff_period(clkdiv, eff_lvl[n]);
    end
  end

  // Prescaler, phase advance and acceleration state for every channel
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        steer_q[n]   <= 2'b00;
        step_q[n]    <= 1'b0;
        presc_q[n]   <= '0;
        level_q[n]   <= '0;
        hold_q[n]    <= '0;
        lastdir_q[n] <= DIR_NONE;
      end
    end else begin
      mode_q <= mode;
      for (int n = 0; n < CHANNELS; n++) begin
        step_q[n] <= 1'b0;
        if (req_dir[n] == DIR_NONE) begin
          presc_q[n]   <= '0;
          hold_q[n]    <= '0;
          level_q[n]   <= '0;
          lastdir_q[n] <= DIR_NONE;
        end else if (req_dir[n] != lastdir_q[n] || mode != mode_q) begin
          // Fresh press, reversal or mode switch: restart a full period
          // while steer keeps its phase so the output never glitches
          presc_q[n]   <= '0;
          hold_q[n]    <= '0;
          level_q[n]   <= '0;
          lastdir_q[n] <= req_dir[n];
        end else if (presc_q[n] >= eff_per[n] - 1'b1) begin
          presc_q[n] <= '0;
          steer_q[n] <= next_phase(steer_q[n], req_dir[n] == DIR_CW);
          step_q[n]  <= 1'b1;
          if (!mode && accel_en) begin
            if (hold_q[n] == HOLD_W'(ACCEL_HOLD - 1)) begin
              hold_q[n] <= '0;
              if (level_q[n] < LVL_W'(ACCEL_STEPS))
                level_q[n] <= level_q[n] + 1'b1;
            end else begin
              hold_q[n] <= hold_q[n] + 1'b1;
            end
          end else begin
            hold_q[n]  <= '0;
            level_q[n] <= '0;
          end
        end else begin
          presc_q[n] <= presc_q[n] + 1'b1;
        end
      end
    end
  end

  // Pack per-channel registers onto the flat output buses
  always_comb begin
    steer = '0;
    step  = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      steer[2*n +: 2] = steer_q[n];
      step[n]         = step_q[n];
    end
  end

endmodule

// File: tb/tb_joy2quad_multi.sv
// Scoreboard bench for joy2quad_multi: stimulus pushes expected step events
// (channel, edge number, new steer phase); a monitor pops them on each step.
module tb_joy2quad_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] clkdiv;
  logic        accel_en;
  logic        mode;
  logic [1:0]  left;
  logic [1:0]  right;
  logic [15:0] analog;
  logic [3:0]  steer;
  logic [1:0]  step;

  joy2quad_multi #(
    .CHANNELS(2), .DIV_W(16), .ACCEL_STEPS(3), .ACCEL_HOLD(16), .DEADZONE(12)
  ) dut (
    .clk_sys(clk), .reset(reset), .clkdiv(clkdiv), .accel_en(accel_en),
    .mode(mode), .left(left), .right(right), .analog(analog),
    .steer(steer), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    int         cyc;
    logic [1:0] st;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         idx [2];
  logic [1:0] seq [4];
  logic [1:0] prev_st [2];
  logic       rs;
  int         fi;
  exp_t       e;

  // Monitor: edge counter, reset-state check, step pops, hold-when-idle check
  always @(posedge clk) begin
    rs  = reset;
    cyc = cyc + 1;
    #2;
    for (int n = 0; n < 2; n++) begin
      if (rs) begin
        checks++;
        if (step[n] !== 1'b0 || steer[2*n +: 2] !== 2'b00) begin
          failures++;
          $display("FAIL reset_state ch%0d cyc=%0d got steer=%b step=%b exp steer=00 step=0",
                   n, cyc, steer[2*n +: 2], step[n]);
        end
      end else if (step[n] === 1'b1) begin
        fi = -1;
        for (int i = 0; i < q.size(); i++)
          if (fi < 0 && q[i].ch == n) fi = i;
        checks++;
        if (fi < 0) begin
          failures++;
          $display("FAIL extra_step ch%0d cyc=%0d got step=1 exp no step", n, cyc);
        end else begin
          e = q[fi];
          q.delete(fi);
          if (e.cyc != cyc) begin
            failures++;
            $display("FAIL step_time ch%0d got=%0d exp=%0d", n, cyc, e.cyc);
          end
          checks++;
          if (steer[2*n +: 2] !== e.st) begin
            failures++;
            $display("FAIL step_phase ch%0d cyc=%0d got=%b exp=%b", n, cyc, steer[2*n +: 2], e.st);
          end
        end
      end else begin
        checks++;
        if (steer[2*n +: 2] !== prev_st[n]) begin
          failures++;
          $display("FAIL steer_hold ch%0d cyc=%0d got=%b exp=%b", n, cyc, steer[2*n +: 2], prev_st[n]);
        end
      end
      prev_st[n] = steer[2*n +: 2];
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_steps(input int ch, input int cw, input int first, input int per,
                            input int n, output int last);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      idx[ch] = cw ? (idx[ch] + 1) % 4 : (idx[ch] + 3) % 4;
      x.ch  = ch;
      x.cyc = first + k * per;
      x.st  = seq[idx[ch]];
      q.push_back(x);
    end
    last = first + (n - 1) * per;
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_steps got=%0d pending exp=0 (next ch%0d at cyc %0d)",
               name, q.size(), q[0].ch, q[0].cyc);
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, l, l1, l2, l3, l4, l5;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    idx[0] = 0; idx[1] = 0;
    prev_st[0] = 2'b00; prev_st[1] = 2'b00;
    reset = 1'b1; clkdiv = 16'd4; accel_en = 1'b0; mode = 1'b0;
    left = 2'b00; right = 2'b00; analog = 16'h0000;
    step_to(3);
    reset = 1'b0;
    step_to(5);
    checks++;
    if (steer !== 4'b0000 || step !== 2'b00) begin
      failures++;
      $display("FAIL post_reset got steer=%b step=%b exp steer=0000 step=00", steer, step);
    end

    // Digital CW at period 4, full Gray cycle
    c = cyc; right = 2'b01;
    push_steps(0, 1, c + 5, 4, 4, l);
    step_to(l + 2); right = 2'b00;
    step_to(cyc + 4);
    check_empty("s1_cw");
    checks++;
    if (steer !== 4'b0000) begin
      failures++;
      $display("FAIL s1_wrap got=%b exp=0000", steer);
    end

    // Both pressed: no motion; release left -> CW after one period
    left = 2'b01; right = 2'b01; c = cyc;
    step_to(c + 50);
    left = 2'b00; c = cyc;
    push_steps(0, 1, c + 5, 4, 2, l);
    step_to(l); right = 2'b00;
    step_to(cyc + 6);
    check_empty("s2_both");

    // Hold-time acceleration 64 -> 32 -> 16 -> 8, saturating at 8
    clkdiv = 16'd64; accel_en = 1'b1; c = cyc; right = 2'b01;
    push_steps(0, 1, c + 65, 64, 16, l1);
    push_steps(0, 1, l1 + 32, 32, 16, l2);
    push_steps(0, 1, l2 + 16, 16, 16, l3);
    push_steps(0, 1, l3 + 8, 8, 24, l4);
    step_to(l4); right = 2'b00;
    step_to(cyc + 3);
    check_empty("s3_accel");
    c = cyc; right = 2'b01;
    push_steps(0, 1, c + 65, 64, 2, l5);
    step_to(l5); right = 2'b00;
    step_to(cyc + 3);
    check_empty("s3_repress");

    // Analog: deadzone edges, slow CW, full-scale both channels, reversal
    accel_en = 1'b0; clkdiv = 16'd32; mode = 1'b1;
    step_to(cyc + 3);
    analog[7:0] = 8'd12;  step_to(cyc + 40);
    analog[7:0] = 8'hF4;  step_to(cyc + 40);
    check_empty("deadzone");
    c = cyc; analog[7:0] = 8'd13;
    push_steps(0, 1, c + 33, 32, 1, l);
    step_to(l); analog[7:0] = 8'd0;
    step_to(cyc + 3);
    c = cyc; analog[7:0] = 8'd20;
    push_steps(0, 1, c + 33, 32, 3, l);
    step_to(l); analog[7:0] = 8'd0;
    step_to(cyc + 3);
    check_empty("analog_slow");
    c = cyc; analog = 16'h807F;
    push_steps(0, 1, c + 5, 4, 5, l);
    push_steps(1, 0, c + 5, 4, 5, l1);
    step_to(l); analog[7:0] = 8'h80;
    push_steps(0, 0, l + 5, 4, 5, l2);
    push_steps(1, 0, l + 4, 4, 5, l3);
    step_to(l2); analog = 16'h0000;
    step_to(cyc + 3);
    check_empty("analog_fast");
    mode = 1'b0;
    step_to(cyc + 3);

    // Reversal mid-count (prescaler at 2 of 4)
    clkdiv = 16'd4; c = cyc; right = 2'b01;
    push_steps(0, 1, c + 5, 4, 1, s);
    step_to(s + 2); right = 2'b00; left = 2'b01;
    push_steps(0, 0, s + 7, 4, 2, l);
    step_to(l); left = 2'b00;
    step_to(cyc + 3);
    check_empty("reversal");

    // Reset pulse while running with a nonzero prescaler
    c = cyc; right = 2'b01;
    push_steps(0, 1, c + 5, 4, 1, s);
    step_to(s + 1); reset = 1'b1; idx[0] = 0; idx[1] = 0;
    step_to(s + 2); reset = 1'b0;
    push_steps(0, 1, s + 7, 4, 2, l);
    step_to(l); right = 2'b00;
    step_to(cyc + 3);
    check_empty("reset_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
